// File: rtl/vga_pkg.sv
// Shared VGA raster constants and types for the draw-stage chain.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    // 1024x768 @ 60 Hz raster
    localparam int HOR_TOTAL   = 1344;
    localparam int VER_TOTAL   = 806;
    localparam int HOR_VISIBLE = 1024;
    localparam int VER_VISIBLE = 768;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int RGB_W   = 12;
    localparam int CNT_W   = 11;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // One pixel's worth of stream fields, used to carry the stream through delay lines
    typedef struct packed {
        cnt_t vcount;
        logic vsync;
        logic vblnk;
        cnt_t hcount;
        logic hsync;
        logic hblnk;
        rgb_t rgb;
    } vga_sig_t;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle passed between draw stages.
// Latency: n/a (wires only).
// Backpressure: none; one pixel per clk, fields always valid.
// Modports: in/slave = consumer side, out/master = producer side.
interface vga_if;
    import vga_pkg::*;

    cnt_t vcount;
    cnt_t hcount;
    logic vsync;
    logic vblnk;
    logic hsync;
    logic hblnk;
    rgb_t rgb;

    modport in     (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport out    (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport slave  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport master (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// Registered delay line for every field of a VGA stream, cleared on reset.
// Latency: STAGES clk cycles.
// Backpressure: none; advances every clk.
// Ports: clk, rst (async active-high), din (vga_if.in), dout (vga_if.out).
module vga_delay
    import vga_pkg::*;
#(
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic rst,
    vga_if.in    din,
    vga_if.out   dout
);

    vga_sig_t din_s;
    vga_sig_t pipe [STAGES];

    assign din_s = '{vcount: din.vcount, vsync: din.vsync, vblnk: din.vblnk,
                     hcount: din.hcount, hsync: din.hsync, hblnk: din.hblnk,
                     rgb:    din.rgb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din_s;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout.vcount = pipe[STAGES-1].vcount;
    assign dout.vsync  = pipe[STAGES-1].vsync;
    assign dout.vblnk  = pipe[STAGES-1].vblnk;
    assign dout.hcount = pipe[STAGES-1].hcount;
    assign dout.hsync  = pipe[STAGES-1].hsync;
    assign dout.hblnk  = pipe[STAGES-1].hblnk;
    assign dout.rgb    = pipe[STAGES-1].rgb;

endmodule

// File: rtl/draw_text_overlay.sv
// Overlays a TEXT_COLS x TEXT_ROWS grid of 8x16 glyphs on the VGA stream.
// Latency: 4 clk, all stream fields aligned.
// Backpressure: none; one pixel per clk.
// Ports: clk, rst (async active-high), vga_in/vga_out (vga_if), xpos/ypos (box origin),
//        char_addr/char_code (char RAM), font_addr/font_line (font ROM); both memories
//        are synchronous read with 1 clk latency.
module draw_text_overlay
    import vga_pkg::*;
#(
    parameter int   TEXT_COLS = 16,
    parameter int   TEXT_ROWS = 16,
    parameter rgb_t FG_RGB    = 12'hFFF,
    parameter logic BG_EN     = 1'b0,
    parameter rgb_t BG_RGB    = 12'h000,
    localparam int  COL_W     = $clog2(TEXT_COLS),
    localparam int  ROW_W     = $clog2(TEXT_ROWS),
    localparam int  ADDR_W    = COL_W + ROW_W
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.in                 vga_in,
    vga_if.out                vga_out,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    output logic [ADDR_W-1:0] char_addr,
    input  logic [7:0]        char_code,
    output logic [10:0]       font_addr,
    input  logic [7:0]        font_line
);

    cnt_t        x0;
    cnt_t        y0;
    logic [11:0] hrel;
    logic [11:0] vrel;
    logic        in_box;
    logic [3:0]  box_q;        // box_q[k] is in_box delayed k+1 clk
    logic [2:0]  px_q [4];     // glyph pixel column, same alignment as box_q
    logic [3:0]  line_q1;
    logic [3:0]  line_q2;
    rgb_t        rgb_sel;
    logic        unused_code_msb;

    vga_if dly ();

    // Code points are 7-bit; the RAM's top bit carries nothing for us.
    assign unused_code_msb = char_code[7];

    // 12-bit relative coordinates: a box hanging past 2047 must not wrap back onto
    // small hcount values, so the >= test against the origin is kept explicit.
    assign hrel   = {1'b0, vga_in.hcount} - {1'b0, x0};
    assign vrel   = {1'b0, vga_in.vcount} - {1'b0, y0};
    assign in_box = (vga_in.hcount >= x0) && (hrel < 12'(GLYPH_W * TEXT_COLS)) &&
                    (vga_in.vcount >= y0) && (vrel < 12'(GLYPH_H * TEXT_ROWS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0        <= '0;
            y0        <= '0;
            char_addr <= '0;
            font_addr <= '0;
            box_q     <= '0;
            line_q1   <= '0;
            line_q2   <= '0;
            for (int i = 0; i < 4; i++) px_q[i] <= '0;
        end else begin
            // Origin only moves at frame start so the box never tears.
            if (vga_in.vcount == '0 && vga_in.hcount == '0) begin
                x0 <= xpos;
                y0 <= ypos;
            end
            char_addr <= {vrel[ROW_W+3:4], hrel[COL_W+2:3]};
            line_q1   <= vrel[3:0];
            line_q2   <= line_q1;
            // char_code answers the char_addr launched one cycle earlier.
            font_addr <= {char_code[6:0], line_q2};
            box_q     <= {box_q[2:0], in_box};
            px_q[0]   <= hrel[2:0];
            for (int i = 1; i < 4; i++) px_q[i] <= px_q[i-1];
        end
    end

    vga_delay #(.STAGES(4)) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (vga_in),
        .dout (dly)
    );

    // Final select sits on registered sources only: the delay line, box_q/px_q and
    // the font ROM output register. Out-of-box pixels never look at font_line, so
    // stale addresses outside the box are harmless.
    always_comb begin
        rgb_sel = dly.rgb;
        if (dly.hblnk || dly.vblnk)
            rgb_sel = '0;
        else if (!box_q[3])
            rgb_sel = dly.rgb;
        else if (font_line[3'd7 - px_q[3]])
            rgb_sel = FG_RGB;
        else
            rgb_sel = BG_EN ? BG_RGB : dly.rgb;
    end

    assign vga_out.vcount = dly.vcount;
    assign vga_out.vsync  = dly.vsync;
    assign vga_out.vblnk  = dly.vblnk;
    assign vga_out.hcount = dly.hcount;
    assign vga_out.hsync  = dly.hsync;
    assign vga_out.hblnk  = dly.hblnk;
    assign vga_out.rgb    = rgb_sel;

endmodule
